// File: rtl/prog_loader.sv
// prog_loader: instruction-memory program loader.
// Receives a framed byte stream (LEN, 2*N data bytes high-first, optional CSUM),
// assembles big-endian 16-bit words and writes them sequentially from BASE_ADDR.
// All state updates on the falling edge of nclk; nreset is async active-low.
// Optional feature macro: LOADER_CSUM_EN (checksum byte and ERR state).
module prog_loader #(
  parameter logic [7:0] BASE_ADDR = 8'h00
) (
  input  logic        nclk,
  input  logic        nreset,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        wr_en,
  output logic [7:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        cpu_halt,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned CNT_W = 9;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN   = 3'd1;
  localparam logic [2:0] S_HI    = 3'd2;
  localparam logic [2:0] S_LO    = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
`ifdef LOADER_CSUM_EN
  localparam logic [2:0] S_CSUM  = 3'd6;
  localparam logic [2:0] S_ERR   = 3'd7;
`endif

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [7:0]       hi_q, hi_d;
  logic [7:0]       addr_q, addr_d;
  logic [15:0]      data_q, data_d;
  logic             rx_ready_q, rx_ready_d;
  logic             wr_en_q, wr_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             halt_q, halt_d;
  logic             accept;
  logic             last_word;
`ifdef LOADER_CSUM_EN
  logic [7:0]       sum_q, sum_d;
  logic             err_q, err_d;
`endif

  assign accept    = rx_valid && rx_ready_q;
  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign last_word = (cnt_inc == len_q);

  // Next-state and next-output logic; outputs are registered from the next state.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef LOADER_CSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LEN;
          addr_d  = BASE_ADDR;
          cnt_d   = '0;
`ifdef LOADER_CSUM_EN
          sum_d   = '0;
`endif
        end
      end
`ifdef LOADER_CSUM_EN
      S_ERR: begin
        if (start) begin
          state_d = S_LEN;
          addr_d  = BASE_ADDR;
          cnt_d   = '0;
          sum_d   = '0;
        end
      end
`endif
      S_LEN: begin
        if (accept) begin
          // A zero length byte encodes a full 256-word program.
          len_d   = (rx_data == 8'd0) ? CNT_W'(256) : CNT_W'(rx_data);
`ifdef LOADER_CSUM_EN
          sum_d   = sum_q + rx_data;
`endif
          state_d = S_HI;
        end
      end
      S_HI: begin
        if (accept) begin
          hi_d    = rx_data;
`ifdef LOADER_CSUM_EN
          sum_d   = sum_q + rx_data;
`endif
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (accept) begin
          data_d  = {hi_q, rx_data};
`ifdef LOADER_CSUM_EN
          sum_d   = sum_q + rx_data;
`endif
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        addr_d = addr_q + 8'd1;
        cnt_d  = cnt_inc;
        if (last_word) begin
`ifdef LOADER_CSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_HI;
        end
      end
`ifdef LOADER_CSUM_EN
      S_CSUM: begin
        if (accept) begin
          state_d = (rx_data == sum_q) ? S_DONE : S_ERR;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    rx_ready_d = (state_d == S_LEN) || (state_d == S_HI) || (state_d == S_LO);
`ifdef LOADER_CSUM_EN
    rx_ready_d = rx_ready_d || (state_d == S_CSUM);
    err_d      = (state_d == S_ERR);
`endif
    wr_en_d = (state_d == S_WRITE);
    busy_d  = rx_ready_d || wr_en_d;
    done_d  = (state_d == S_DONE);
`ifdef LOADER_CSUM_EN
    halt_d  = busy_d || err_d;
`else
    halt_d  = busy_d;
`endif
  end

  // State and output registers, falling-edge clocked with async reset.
  always_ff @(negedge nclk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      hi_q       <= '0;
      addr_q     <= BASE_ADDR;
      data_q     <= '0;
      rx_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      halt_q     <= 1'b0;
`ifdef LOADER_CSUM_EN
      sum_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rx_ready_q <= rx_ready_d;
      wr_en_q    <= wr_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      halt_q     <= halt_d;
`ifdef LOADER_CSUM_EN
      sum_q      <= sum_d;
      err_q      <= err_d;
`endif
    end
  end

  assign rx_ready = rx_ready_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = addr_q;
  assign wr_data  = data_q;
  assign cpu_halt = halt_q;
  assign busy     = busy_q;
  assign done     = done_q;
`ifdef LOADER_CSUM_EN
  assign err      = err_q;
`else
  assign err      = 1'b0;
`endif

endmodule
